// File: rtl/wwvb_pkg.sv
// rtl/wwvb_pkg.sv - shared cell encoding, modulator states and marker positions
package wwvb_pkg;

  typedef enum logic [1:0] {
    CELL_ZERO = 2'b00,
    CELL_ONE  = 2'b01,
    CELL_REF  = 2'b10
  } t_cell_value;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } t_mod_state;

  localparam int N_MARKERS = 7;
  localparam logic [5:0] MARKER_POS [N_MARKERS] = '{6'd0, 6'd9, 6'd19, 6'd29, 6'd39, 6'd49, 6'd59};

  // True when the given second of the minute must carry a marker (REF) cell.
  function automatic logic is_marker_pos(input logic [5:0] sec_idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_MARKERS; i++) begin
      if (MARKER_POS[i] == sec_idx) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/wwvb_marker_check.sv
// rtl/wwvb_marker_check.sv - sticky marker-position checker, built only with WWVB_MARKER_CHECK_EN
module wwvb_marker_check
  import wwvb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic [5:0] sec_idx,
  input  logic [1:0] cur_cell,
  input  logic       err_clr,
  output logic       frame_err
);

  logic cell_is_ref;
  logic mismatch;

  // An invalid cell is treated as a marker, so anything that is not ZERO/ONE counts as REF.
  assign cell_is_ref = (cur_cell != CELL_ZERO) && (cur_cell != CELL_ONE);
  assign mismatch    = strobe && (cell_is_ref != is_marker_pos(sec_idx));

  // Sticky error flag; a new mismatch beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else if (mismatch) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

endmodule

// File: rtl/wwvb_modulator.sv
// rtl/wwvb_modulator.sv - WWVB envelope and gated carrier from the timeframe head cell; marker check under WWVB_MARKER_CHECK_EN
module wwvb_modulator
  import wwvb_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int ZERO_TICKS    = 2,
  parameter int ONE_TICKS     = 5,
  parameter int REF_TICKS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hb_10Hz,
  input  logic       carrier_clk,
  input  logic       enable,
  input  logic [1:0] cell_in,
  input  logic       err_clr,
  output logic       advance,
  output logic       power_low,
  output logic       wwvb,
  output logic [5:0] sec_idx,
  output logic       busy,
  output logic       cell_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_SEC - 1);

  t_mod_state    state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next, tick_inc;
  logic [TW-1:0] dur, dur_next;
  logic [1:0]    cur_cell, cur_cell_next;
  logic          power_low_next;
  logic          advance_next;
  logic [5:0]    sec_idx_next;
  logic          cell_err_next;
  logic          start;

  // Reduced-power length for a cell; invalid cells are sent as markers.
  function automatic logic [TW-1:0] cell_dur(input logic [1:0] c);
    case (c)
      CELL_ZERO: cell_dur = TW'(ZERO_TICKS);
      CELL_ONE:  cell_dur = TW'(ONE_TICKS);
      default:   cell_dur = TW'(REF_TICKS);
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the per-second datapath updates.
  always_comb begin
    state_next     = state;
    tick_cnt_next  = tick_cnt;
    dur_next       = dur;
    cur_cell_next  = cur_cell;
    power_low_next = power_low;
    advance_next   = 1'b0;
    sec_idx_next   = sec_idx;
    cell_err_next  = cell_err & ~err_clr;
    start          = 1'b0;
    tick_inc       = tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        tick_cnt_next  = '0;
        power_low_next = 1'b0;
        if (hb_10Hz && enable) start = 1'b1;
      end
      LOW: begin
        if (hb_10Hz) begin
          tick_cnt_next = tick_inc;
          if (tick_inc == dur) begin
            state_next     = HIGH;
            power_low_next = 1'b0;
          end
        end
      end
      HIGH: begin
        if (hb_10Hz) begin
          if (tick_cnt == LAST_TICK) begin
            if (enable) begin
              start = 1'b1;
            end else begin
              state_next    = IDLE;
              tick_cnt_next = '0;
            end
          end else begin
            tick_cnt_next = tick_inc;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        tick_cnt_next  = '0;
        power_low_next = 1'b0;
      end
    endcase

    // A second start overrides whatever the state branch decided.
    if (start) begin
      state_next     = LOW;
      tick_cnt_next  = '0;
      cur_cell_next  = cell_in;
      dur_next       = cell_dur(cell_in);
      power_low_next = 1'b1;
      advance_next   = 1'b1;
      if (state == IDLE) begin
        sec_idx_next = 6'd0;
      end else if (sec_idx == 6'd59) begin
        sec_idx_next = 6'd0;
      end else begin
        sec_idx_next = sec_idx + 6'd1;
      end
      if (cell_in == 2'b11) cell_err_next = 1'b1;
    end
  end

  // Output and datapath registers; wwvb uses the next envelope so it lines up with power_low.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      dur       <= '0;
      cur_cell  <= CELL_ZERO;
      power_low <= 1'b0;
      wwvb      <= 1'b0;
      advance   <= 1'b0;
      sec_idx   <= 6'd0;
      cell_err  <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt_next;
      dur       <= dur_next;
      cur_cell  <= cur_cell_next;
      power_low <= power_low_next;
      wwvb      <= carrier_clk & ~power_low_next;
      advance   <= advance_next;
      sec_idx   <= sec_idx_next;
      cell_err  <= cell_err_next;
    end
  end

  assign busy = (state != IDLE);

`ifdef WWVB_MARKER_CHECK_EN
  // advance marks the cycle where cur_cell and sec_idx both hold the new second.
  wwvb_marker_check u_marker_check (
    .clk       (clk),
    .reset     (reset),
    .strobe    (advance),
    .sec_idx   (sec_idx),
    .cur_cell  (cur_cell),
    .err_clr   (err_clr),
    .frame_err (frame_err)
  );
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_wwvb_modulator.sv
// tb/tb_wwvb_modulator.sv - randomized self-checking bench for wwvb_modulator against a tick-level model
module tb_wwvb_modulator;
  import wwvb_pkg::*;

  localparam int TPS = 10;
  localparam int ZT  = 2;
  localparam int OT  = 5;
  localparam int RT  = 8;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset, hb_10Hz, carrier_clk, enable, err_clr;
  logic [1:0] cell_in;
  logic       advance, power_low, wwvb, busy, cell_err, frame_err;
  logic [5:0] sec_idx;

  int errors = 0;
  int checks = 0;

  // model of the transmitter, in ticks since the start of the current second
  bit m_active, m_cerr, m_ferr, prev_hb, marker_feed;
  int m_k, m_dur, m_sec;
  int adv_cnt, low_cyc, wraps, last_sec;

  wwvb_modulator #(
    .TICKS_PER_SEC (TPS),
    .ZERO_TICKS    (ZT),
    .ONE_TICKS     (OT),
    .REF_TICKS     (RT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hb_10Hz     (hb_10Hz),
    .carrier_clk (carrier_clk),
    .enable      (enable),
    .cell_in     (cell_in),
    .err_clr     (err_clr),
    .advance     (advance),
    .power_low   (power_low),
    .wwvb        (wwvb),
    .sec_idx     (sec_idx),
    .busy        (busy),
    .cell_err    (cell_err),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit marker_sec(input int s);
    return (s == 0) || (s % 10 == 9);
  endfunction

  function automatic int dur_of(input logic [1:0] c);
    if (c == 2'b00) return ZT;
    if (c == 2'b01) return OT;
    return RT;
  endfunction

  // Apply current inputs for one clock, advance the model, and compare all outputs after the edge.
  task automatic cycle();
    bit start, b2b, exp_adv, exp_low, exp_wwvb, is_ref;
    start = 0; b2b = 0; exp_adv = 0;
    carrier_clk = 1'($urandom);
    if (marker_feed)
      cell_in = marker_sec(m_active ? (m_sec + 1) % 60 : 0) ? 2'b10 : 2'($urandom_range(0, 1));
    if (reset) begin
      m_active = 0; m_k = 0; m_sec = 0; m_cerr = 0; m_ferr = 0;
    end else begin
      if (hb_10Hz) begin
        if (m_active) begin
          m_k++;
          if (m_k == TPS) begin
            if (enable) begin start = 1; b2b = 1; end
            else m_active = 0;
          end
        end else if (enable) begin
          start = 1;
        end
      end
      if (err_clr) begin m_cerr = 0; m_ferr = 0; end
      if (start) begin
        m_sec    = b2b ? (m_sec + 1) % 60 : 0;
        m_active = 1;
        m_k      = 0;
        m_dur    = dur_of(cell_in);
        exp_adv  = 1;
        if (cell_in == 2'b11) m_cerr = 1;
        is_ref = (cell_in != 2'b00) && (cell_in != 2'b01);
`ifdef WWVB_MARKER_CHECK_EN
        if (is_ref != marker_sec(m_sec)) m_ferr = 1;
`endif
      end
    end
    exp_low  = m_active && (m_k < m_dur);
    exp_wwvb = reset ? 1'b0 : (carrier_clk & ~exp_low);

    @(posedge clk);
    #1;
    check("advance", advance, exp_adv);
    check("power_low", power_low, exp_low);
    check("wwvb", wwvb, exp_wwvb);
    check("busy", busy, m_active);
    check("sec_idx", sec_idx, m_sec);
    check("cell_err", cell_err, m_cerr);
    if (!start) check("frame_err", frame_err, m_ferr);
    if (advance) adv_cnt++;
    if (power_low) low_cyc++;
    if (last_sec == 59 && sec_idx == 6'd0) wraps++;
    last_sec = int'(sec_idx);
    prev_hb  = hb_10Hz;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      hb_10Hz = 1'b0;
      repeat (GAP - 1) cycle();
      hb_10Hz = 1'b1;
      cycle();
    end
    hb_10Hz = 1'b0;
  endtask

  initial begin
    int gap;
    reset = 1'b1; hb_10Hz = 1'b0; carrier_clk = 1'b0; enable = 1'b1;
    cell_in = 2'b00; err_clr = 1'b0; marker_feed = 0;
    m_active = 0; m_k = 0; m_dur = 0; m_sec = 0; m_cerr = 0; m_ferr = 0;
    prev_hb = 0; adv_cnt = 0; low_cyc = 0; wraps = 0; last_sec = 0;

    // reset held with ticks pulsing
    for (int i = 0; i < 5; i++) begin
      hb_10Hz = 1'(i % 2);
      cycle();
    end
    check("rst_adv_cnt", adv_cnt, 0);
    reset = 1'b0; hb_10Hz = 1'b0; enable = 1'b0;

    // ZERO second, enable dropped at tick 3
    adv_cnt = 0; low_cyc = 0;
    cell_in = 2'b00; enable = 1'b1;
    ticks(1);
    ticks(3);
    enable = 1'b0;
    ticks(9);
    check("zero_adv_cnt", adv_cnt, 1);
    check("zero_low_cyc", low_cyc, ZT * GAP);
    check("zero_idle_busy", busy, 0);
    check("zero_sec_hold", sec_idx, 0);

    // back-to-back ONE then REF
    adv_cnt = 0; low_cyc = 0;
    cell_in = 2'b01; enable = 1'b1;
    ticks(1);
    cell_in = 2'b10;
    ticks(10);
    enable = 1'b0;
    ticks(11);
    check("b2b_adv_cnt", adv_cnt, 2);
    check("b2b_low_cyc", low_cyc, (OT + RT) * GAP);
    check("b2b_sec_idx", sec_idx, 1);
    check("b2b_busy", busy, 0);

    // invalid cell, then clear; then clear coinciding with a new invalid cell
    low_cyc = 0;
    cell_in = 2'b11; enable = 1'b1;
    ticks(1);
    enable = 1'b0;
    check("inv_cell_err", cell_err, 1);
    ticks(11);
    check("inv_low_cyc", low_cyc, RT * GAP);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("inv_cleared", cell_err, 0);
    enable = 1'b1;
    repeat (GAP - 1) cycle();
    hb_10Hz = 1'b1; err_clr = 1'b1; cycle();
    hb_10Hz = 1'b0; err_clr = 1'b0; enable = 1'b0;
    check("inv_set_wins", cell_err, 1);
    ticks(11);

    // randomized traffic, including mid-second resets and enable toggling
    repeat (400) begin
      gap = $urandom_range(2, 6);
      for (int c = 0; c < gap; c++) begin
        hb_10Hz = (c == gap - 1);
        if ($urandom_range(0, 29) == 0) enable = ~enable;
        cell_in = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        err_clr = !prev_hb && !hb_10Hz && ($urandom_range(0, 39) == 0);
        reset   = ($urandom_range(0, 399) == 0);
        cycle();
      end
    end
    reset = 1'b0; err_clr = 1'b0; hb_10Hz = 1'b0; enable = 1'b0;

    // full correct marker pattern across the 59->0 wrap
    reset = 1'b1; cycle(); reset = 1'b0;
    wraps = 0; marker_feed = 1; enable = 1'b1;
    ticks(1 + 61 * TPS);
    enable = 1'b0;
    ticks(11);
    marker_feed = 0;
    check("mark_wraps", wraps, 1);
    check("mark_sec_idx", sec_idx, 1);
    check("mark_frame_ok", frame_err, 0);

`ifdef WWVB_MARKER_CHECK_EN
    // ZERO cell where a marker belongs
    reset = 1'b1; cycle(); reset = 1'b0;
    cell_in = 2'b00; enable = 1'b1;
    ticks(1);
    enable = 1'b0;
    cycle();
    cycle();
    check("mark_zero_at_0", frame_err, 1);
    ticks(11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
